// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter for a two-source register file write port, plus a
// busy-register scoreboard for long-latency results and the stall logic that
// the scoreboard drives.
//
// Requester A (ALU path) normally wins. Requester B (load / long-latency unit)
// wins when A is idle, or when B has lost StarveMax times in a row. The granted
// writeback is registered, so the register file sees it one cycle after the
// transfer edge.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   A_valid/A_rd/A_data       requester A writeback request
//   A_ready                   A granted this cycle (combinational)
//   B_valid/B_rd/B_data       requester B writeback request
//   B_ready                   B granted this cycle (combinational)
//   iss_valid/iss_rd          long-latency op issued; marks iss_rd busy
//   R1, R2                    source registers of the current instruction
//   Stall                     current instruction must not read the regfile
//   RegWrite/W1/WD1           register file write port
//   busy                      scoreboard, bit n = register n awaits B
// -----------------------------------------------------------------------------
module wb_arbiter #(
   parameter int Width     = 32,
   parameter int StarveMax = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             A_valid,
   input  logic [4:0]       A_rd,
   input  logic [Width-1:0] A_data,
   output logic             A_ready,
   input  logic             B_valid,
   input  logic [4:0]       B_rd,
   input  logic [Width-1:0] B_data,
   output logic             B_ready,
   input  logic             iss_valid,
   input  logic [4:0]       iss_rd,
   input  logic [4:0]       R1,
   input  logic [4:0]       R2,
   output logic             Stall,
   output logic             RegWrite,
   output logic [4:0]       W1,
   output logic [Width-1:0] WD1,
   output logic [31:0]      busy
);

   // Counter wide enough to hold StarveMax (at least one bit).
   localparam int CntW = (StarveMax < 1) ? 1 : $clog2(StarveMax + 1);
   localparam logic [CntW-1:0] StarveLim = CntW'(StarveMax);

   logic [CntW-1:0]  starve_q, starve_d;
   logic             regwrite_q, regwrite_d;
   logic [4:0]       w1_q, w1_d;
   logic [Width-1:0] wd1_q, wd1_d;
   logic [31:0]      busy_q, busy_d;

   logic             starved;
   logic [4:0]       win_rd;
   logic [Width-1:0] win_data;

   // ---------------------------------------------------------------------------
   // Grant. Ready is held low during reset so nothing is accepted that the
   // reset would then have to discard.
   // ---------------------------------------------------------------------------
   assign starved = (starve_q == StarveLim);

   // NOTE: every signal written in a combinational block gets a default first;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      A_ready = 1'b0;
      B_ready = 1'b0;
      if (rst) begin
         if (A_valid && B_valid) begin
            if (starved) B_ready = 1'b1;
            else         A_ready = 1'b1;
         end else if (A_valid) begin
            A_ready = 1'b1;
         end else if (B_valid) begin
            B_ready = 1'b1;
         end
      end
   end

   assign win_rd   = B_ready ? B_rd   : A_rd;
   assign win_data = B_ready ? B_data : A_data;

   // ---------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------
   always_comb begin
      // Starvation: count B's losses, forget them as soon as B wins or leaves.
      starve_d = starve_q;
      if (!B_valid || B_ready) begin
         starve_d = '0;
      end else if (A_ready && !starved) begin
         starve_d = starve_q + CntW'(1);
      end

      // Writes to r0 are accepted but dropped; W1/WD1 keep their last value.
      regwrite_d = (A_ready || B_ready) && (win_rd != 5'd0);
      w1_d       = regwrite_d ? win_rd   : w1_q;
      wd1_d      = regwrite_d ? win_data : wd1_q;

      // Scoreboard: the clear is applied first so that a same-edge issue to
      // the same register leaves the bit set.
      busy_d = busy_q;
      if (B_ready)                          busy_d[B_rd]   = 1'b0;
      if (iss_valid && (iss_rd != 5'd0))    busy_d[iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q   <= '0;
         regwrite_q <= 1'b0;
         w1_q       <= 5'd0;
         wd1_q      <= '0;
         busy_q     <= '0;
      end else begin
         starve_q   <= starve_d;
         regwrite_q <= regwrite_d;
         w1_q       <= w1_d;
         wd1_q      <= wd1_d;
         busy_q     <= busy_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Stall: a source is pending in the scoreboard, or is being written this
   // cycle (the regfile has no write-to-read bypass).
   // ---------------------------------------------------------------------------
   always_comb begin
      Stall = 1'b0;
      if ((R1 != 5'd0) && busy_q[R1]) Stall = 1'b1;
      if ((R2 != 5'd0) && busy_q[R2]) Stall = 1'b1;
      if (regwrite_q && (w1_q != 5'd0) && ((w1_q == R1) || (w1_q == R2)))
         Stall = 1'b1;
   end

   assign RegWrite = regwrite_q;
   assign W1       = w1_q;
   assign WD1      = wd1_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed bench for wb_arbiter (Width=32, StarveMax=3). Inputs change one
// time unit after a rising edge; combinational outputs are checked one unit
// later and registered outputs one unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        A_valid;
   logic [4:0]  A_rd;
   logic [31:0] A_data;
   logic        A_ready;
   logic        B_valid;
   logic [4:0]  B_rd;
   logic [31:0] B_data;
   logic        B_ready;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [4:0]  R1;
   logic [4:0]  R2;
   logic        Stall;
   logic        RegWrite;
   logic [4:0]  W1;
   logic [31:0] WD1;
   logic [31:0] busy;

   int n_checks = 0;
   int n_errors = 0;

   wb_arbiter #(.Width(32), .StarveMax(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .A_valid  (A_valid),
      .A_rd     (A_rd),
      .A_data   (A_data),
      .A_ready  (A_ready),
      .B_valid  (B_valid),
      .B_rd     (B_rd),
      .B_data   (B_data),
      .B_ready  (B_ready),
      .iss_valid(iss_valid),
      .iss_rd   (iss_rd),
      .R1       (R1),
      .R2       (R2),
      .Stall    (Stall),
      .RegWrite (RegWrite),
      .W1       (W1),
      .WD1      (WD1),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      A_valid   = 1'b0;
      B_valid   = 1'b0;
      iss_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      A_valid   = 1'b0;
      A_rd      = 5'd0;
      A_data    = 32'h0;
      B_valid   = 1'b0;
      B_rd      = 5'd0;
      B_data    = 32'h0;
      iss_valid = 1'b0;
      iss_rd    = 5'd0;
      R1        = 5'd0;
      R2        = 5'd0;

      // ---------------- reset state ----------------
      #2;
      A_valid = 1'b1;
      A_rd    = 5'd4;
      #1;
      check("rst_A_ready",  32'(A_ready),  0);
      check("rst_B_ready",  32'(B_ready),  0);
      check("rst_RegWrite", 32'(RegWrite), 0);
      check("rst_W1",       32'(W1),       0);
      check("rst_WD1",      WD1,           0);
      check("rst_busy",     busy,          0);
      check("rst_Stall",    32'(Stall),    0);
      A_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();

      // ---------------- single A transfer ----------------
      A_valid = 1'b1; A_rd = 5'd5; A_data = 32'hAA;
      #1;
      check("a_only_A_ready", 32'(A_ready), 1);
      check("a_only_B_ready", 32'(B_ready), 0);
      tick();
      check("a_wb_RegWrite", 32'(RegWrite), 1);
      check("a_wb_W1",       32'(W1),       5);
      check("a_wb_WD1",      WD1,           32'hAA);
      A_valid = 1'b0;
      R1 = 5'd5;
      #1;
      check("a_wb_fwd_Stall", 32'(Stall), 1);
      tick();
      check("a_idle_RegWrite", 32'(RegWrite), 0);
      check("a_idle_W1",       32'(W1),       5);
      check("a_idle_WD1",      WD1,           32'hAA);
      check("a_idle_Stall",    32'(Stall),    0);
      R1 = 5'd0;

      // ---------------- A write to r0 is dropped ----------------
      A_valid = 1'b1; A_rd = 5'd0; A_data = 32'h55;
      #1;
      check("r0_A_ready", 32'(A_ready), 1);
      tick();
      check("r0_RegWrite", 32'(RegWrite), 0);
      check("r0_W1",       32'(W1),       5);
      check("r0_WD1",      WD1,           32'hAA);
      A_valid = 1'b0;

      // ---------------- both valid: A,A,A,B,A,A,A,B ----------------
      A_valid = 1'b1; A_rd = 5'd1; A_data = 32'h11;
      B_valid = 1'b1; B_rd = 5'd2; B_data = 32'h22;
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("rr%0d_A_ready", i), 32'(A_ready), (i % 4 == 3) ? 0 : 1);
         check($sformatf("rr%0d_B_ready", i), 32'(B_ready), (i % 4 == 3) ? 1 : 0);
         tick();
         check($sformatf("rr%0d_W1", i), 32'(W1), (i % 4 == 3) ? 2 : 1);
      end

      // ---------------- starve count cleared when B drops ----------------
      for (int i = 0; i < 2; i++) begin
         #1;
         check($sformatf("pre%0d_A_ready", i), 32'(A_ready), 1);
         tick();
      end
      B_valid = 1'b0;
      #1;
      check("drop_A_ready", 32'(A_ready), 1);
      tick();
      B_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("post%0d_B_ready", i), 32'(B_ready), (i == 3) ? 1 : 0);
         tick();
      end
      idle_inputs();

      // ---------------- B only ----------------
      B_valid = 1'b1; B_rd = 5'd2; B_data = 32'h22;
      #1;
      check("b_only_A_ready", 32'(A_ready), 0);
      check("b_only_B_ready", 32'(B_ready), 1);
      tick();
      B_valid = 1'b0;
      check("b_only_WD1", WD1, 32'h22);

      // ---------------- scoreboard stall on r7 ----------------
      iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
      check("iss7_busy", busy, 32'h0000_0080);
      iss_valid = 1'b0;
      R1 = 5'd7;
      #1;
      check("iss7_Stall_R1", 32'(Stall), 1);
      tick();
      check("iss7_Stall_hold", 32'(Stall), 1);
      R1 = 5'd0; R2 = 5'd7;
      #1;
      check("iss7_Stall_R2", 32'(Stall), 1);
      R2 = 5'd0; R1 = 5'd7;
      B_valid = 1'b1; B_rd = 5'd7; B_data = 32'h77;
      #1;
      check("b7_B_ready", 32'(B_ready), 1);
      check("b7_Stall_pre", 32'(Stall), 1);
      tick();
      B_valid = 1'b0;
      #1;
      check("b7_busy",     busy,          0);
      check("b7_RegWrite", 32'(RegWrite), 1);
      check("b7_W1",       32'(W1),       7);
      check("b7_WD1",      WD1,           32'h77);
      check("b7_Stall_fwd", 32'(Stall),   1);
      tick();
      check("b7_RegWrite_off", 32'(RegWrite), 0);
      check("b7_Stall_off",    32'(Stall),    0);
      R1 = 5'd0;

      // ---------------- set wins over clear, r0 issue, A ignores busy ----------------
      iss_valid = 1'b1; iss_rd = 5'd9;
      tick();
      check("iss9_busy", busy, 32'h0000_0200);
      B_valid = 1'b1; B_rd = 5'd9; B_data = 32'h99;
      tick();
      check("setclr9_busy", busy,     32'h0000_0200);
      check("setclr9_W1",   32'(W1),  9);
      B_valid = 1'b0; iss_rd = 5'd0;
      tick();
      check("iss0_busy", busy, 32'h0000_0200);
      iss_valid = 1'b0;
      A_valid = 1'b1; A_rd = 5'd9; A_data = 32'h33;
      tick();
      check("a9_busy", busy,  32'h0000_0200);
      check("a9_WD1",  WD1,   32'h33);
      A_valid = 1'b0;
      B_valid = 1'b1; B_rd = 5'd9;
      tick();
      check("clr9_busy", busy, 0);
      B_valid = 1'b0;

      // ---------------- asynchronous reset mid-cycle ----------------
      iss_valid = 1'b1; iss_rd = 5'd7;
      A_valid = 1'b1; A_rd = 5'd3; A_data = 32'h3C;
      tick();
      check("pre_rst_busy",     busy,          32'h0000_0080);
      check("pre_rst_RegWrite", 32'(RegWrite), 1);
      check("pre_rst_W1",       32'(W1),       3);
      iss_valid = 1'b0;
      R1 = 5'd7;
      #2;
      rst = 1'b0;
      #1;
      check("async_RegWrite", 32'(RegWrite), 0);
      check("async_W1",       32'(W1),       0);
      check("async_WD1",      WD1,           0);
      check("async_busy",     busy,          0);
      check("async_A_ready",  32'(A_ready),  0);
      check("async_Stall",    32'(Stall),    0);
      tick();
      check("in_rst_RegWrite", 32'(RegWrite), 0);
      #3;
      rst = 1'b1;
      A_valid = 1'b0;
      #1;
      check("rel_A_ready", 32'(A_ready), 0);
      tick();
      check("rel_RegWrite", 32'(RegWrite), 0);
      check("rel_W1",       32'(W1),       0);
      R1 = 5'd0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter Width, default 32: data width of the register file write port and of the writeback requesters.
REQ-002 Parameter StarveMax, default 3: maximum consecutive losses by requester B before B is forced to win.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 A_valid  input  1  requester A (ALU path) writeback request.
REQ-006 A_rd  input  5  destination register for A.
REQ-007 A_data  input  Width  write data for A.
REQ-008 A_ready  output  1  A granted this cycle.
REQ-009 B_valid  input  1  requester B (long-latency/load unit) writeback request.
REQ-010 B_rd  input  5  destination register for B.
REQ-011 B_data  input  Width  write data for B.
REQ-012 B_ready  output  1  B granted this cycle.
REQ-013 iss_valid  input  1  a long-latency op is issued this cycle; its result returns via B.
REQ-014 iss_rd  input  5  destination register of the issued op.
REQ-015 R1, R2  input  5 each  source registers of the current instruction.
REQ-016 Stall  output  1  current instruction must not read the register file this cycle.
REQ-017 RegWrite  output  1  register file write enable.
REQ-018 W1  output  5  register file write address.
REQ-019 WD1  output  Width  register file write data.
REQ-020 busy  output  32  scoreboard; bit n set = register n awaiting a B writeback.

Function
REQ-021 Only one requester valid: that requester is granted.
REQ-022 Both valid: A is granted, except when starve count equals StarveMax, in which case B is granted.
REQ-023 A_ready and B_ready are combinational and one-hot or zero; neither is asserted when its valid is low.
REQ-024 A transfer occurs on the edge where valid and ready are both high; requesters hold valid, rd and data stable until ready.
REQ-025 On a transfer edge: RegWrite<=1, W1<=rd and WD1<=data of the granted requester; latency is exactly one cycle.
REQ-026 No transfer: RegWrite<=0, and W1 and WD1 hold their previous values.
REQ-027 Transfer with rd=0: accepted (ready asserted), RegWrite<=0, W1 and WD1 unchanged; counts as a grant for starvation purposes.
REQ-028 Starve counter: increments (saturating at StarveMax) on each edge where B_valid=1 and A is granted; cleared on a B grant or whenever B_valid=0.
REQ-029 Scoreboard set: iss_valid=1 with iss_rd!=0 sets busy[iss_rd] at the edge.
REQ-030 Scoreboard clear: a B transfer clears busy[B_rd] at the edge; A transfers do not affect busy.
REQ-031 Set and clear of the same bit on the same edge: set wins.
REQ-032 busy[0] is always 0.
REQ-033 Stall = (R1!=0 and busy[R1]) or (R2!=0 and busy[R2]) or (RegWrite=1 and W1!=0 and (W1==R1 or W1==R2)); combinational.
REQ-034 iss_valid is not gated by Stall; upstream qualifies it.

Reset
REQ-035 rst low asynchronously forces RegWrite=0, W1=0, WD1=0, busy=0 and starve count=0.
REQ-036 While rst is low, A_ready=0 and B_ready=0, and Stall follows REQ-033 using the reset state values.
REQ-037 Reset asserted with a transfer in flight: the transfer is discarded, and no write occurs after reset release.

Verification
REQ-038 A_valid=1, A_rd=5, A_data=0xAA, B idle -> A_ready=1; next cycle RegWrite=1, W1=5, WD1=0xAA; the cycle after that, RegWrite=0.
REQ-039 A and B both valid continuously (StarveMax=3) -> grants are A,A,A,B,A,A,A,B...; B_ready is high on every 4th cycle.
REQ-040 iss_valid=1, iss_rd=7; then R1=7 -> Stall=1 until a B transfer with B_rd=7; after that, Stall stays 1 for one more cycle (RegWrite=1, W1=7), then 0.
REQ-041 Same edge: iss_valid=1, iss_rd=9 and B transfer with B_rd=9 -> busy[9]=1 afterwards; iss_rd=0 -> busy unchanged.
REQ-042 A transfer with A_rd=0, A_data=0x55 -> A_ready=1; next cycle RegWrite=0, W1 and WD1 unchanged.
REQ-043 rst pulsed low mid-cycle with busy=0x0000_0080 and RegWrite=1 -> all outputs 0 immediately, without waiting for clk.
